// File: rtl/regression_mac_sequencer_if.sv
// Operand/result handshake bundle for regression_mac_sequencer.
// master: operand source + result consumer side (drives operands and out_ready).
// slave : the sequencer itself (drives in_ready, result, status).
//   in_valid/in_ready  operand set handshake, c0 (ACC_W), c1..c3 and f0..f2 (DATA_W)
//   out_valid/out_ready result handshake, y (ACC_W), ovf, busy
interface regression_mac_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [ACC_W-1:0]  c0;
   logic [DATA_W-1:0] c1;
   logic [DATA_W-1:0] c2;
   logic [DATA_W-1:0] c3;
   logic [DATA_W-1:0] f0;
   logic [DATA_W-1:0] f1;
   logic [DATA_W-1:0] f2;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  y;
   logic              ovf;
   logic              busy;

   modport master (
      output in_valid, c0, c1, c2, c3, f0, f1, f2, out_ready,
      input  in_ready, out_valid, y, ovf, busy
   );

   modport slave (
      input  in_valid, c0, c1, c2, c3, f0, f1, f2, out_ready,
      output in_ready, out_valid, y, ovf, busy
   );
endinterface

// File: rtl/regression_mac_sequencer.sv
// Purpose : y = c0 + c1*f0 + c2*f1 + c3*f2 with one shared multiplier and accumulator.
// Latency : out_valid rises 4 cycles after the accepting cycle; one result per 5 cycles.
// Backpres: in_ready low while busy; result held in DONE until out_ready.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  regression_mac_sequencer_if.slave (operands in, y/ovf/busy out)
// Parameters: DATA_W (c1..c3, f0..f2 width), ACC_W (c0/acc/y width, ACC_W >= 2*DATA_W).
// Build option: define REG_SAT_EN to clamp the accumulator at all-ones on carry-out
// instead of wrapping modulo 2^ACC_W. ovf is set on any carry-out in both builds.
module regression_mac_sequencer #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   regression_mac_sequencer_if.slave    bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Operands captured at accept; the live bus is never looked at again until IDLE.
   typedef struct packed {
      logic [DATA_W-1:0] c1;
      logic [DATA_W-1:0] c2;
      logic [DATA_W-1:0] c3;
      logic [DATA_W-1:0] f0;
      logic [DATA_W-1:0] f1;
      logic [DATA_W-1:0] f2;
   } ops_t;

   logic [1:0]          state;
   logic [1:0]          idx;
   ops_t                ops;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    y_q;
   logic                ovf_q;

   logic                accept;
   logic                last_term;
   logic [DATA_W-1:0]   mul_a;
   logic [DATA_W-1:0]   mul_b;
   logic [2*DATA_W-1:0] prod;
   logic [ACC_W:0]      sum;
   logic [ACC_W-1:0]    acc_next;

   assign accept    = (state == S_IDLE) && bus.in_valid;
   assign last_term = (idx == 2'd2);

   // Term select: idx 0 -> c1*f0, 1 -> c2*f1, 2 -> c3*f2.
   always_comb begin
      mul_a = ops.c1;
      mul_b = ops.f0;
      case (idx)
         2'd1: begin
            mul_a = ops.c2;
            mul_b = ops.f1;
         end
         2'd2: begin
            mul_a = ops.c3;
            mul_b = ops.f2;
         end
         default: begin
            mul_a = ops.c1;
            mul_b = ops.f0;
         end
      endcase
   end

   // Full-width product, zero-extended into the accumulator; the extra sum bit is the carry.
   assign prod = {{DATA_W{1'b0}}, mul_a} * {{DATA_W{1'b0}}, mul_b};
   assign sum  = {1'b0, acc} + {1'b0, ACC_W'(prod)};

`ifdef REG_SAT_EN
   // Once clamped, every later non-zero term carries again, so the clamp holds by itself.
   assign acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   assign acc_next = sum[ACC_W-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= 2'd0;
         ops   <= '0;
         acc   <= '0;
         y_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  ops.c1 <= bus.c1;
                  ops.c2 <= bus.c2;
                  ops.c3 <= bus.c3;
                  ops.f0 <= bus.f0;
                  ops.f1 <= bus.f1;
                  ops.f2 <= bus.f2;
                  acc    <= bus.c0;
                  ovf_q  <= 1'b0;
                  idx    <= 2'd0;
                  state  <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc_next;
               if (sum[ACC_W]) begin
                  ovf_q <= 1'b1;
               end
               if (last_term) begin
                  // y is a separate register so it survives the next accept reloading acc.
                  y_q   <= acc_next;
                  idx   <= 2'd0;
                  state <= S_DONE;
               end else begin
                  idx <= idx + 2'd1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               idx   <= 2'd0;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.y         = y_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_regression_mac_sequencer.sv
// Bench for regression_mac_sequencer: directed scenarios plus random sets,
// scoreboard of expected (y, ovf) pushed on drive and popped on result handshake.
module tb_regression_mac_sequencer;
   localparam int DW = 16;
   localparam int AW = 32;

   typedef struct {
      logic [AW-1:0] y;
      logic          ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   regression_mac_sequencer_if #(.DATA_W(DW), .ACC_W(AW)) bus();
   regression_mac_sequencer #(.DATA_W(DW), .ACC_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   exp_t exp_q[$];
   int   acc_q[$];
   logic tp_mode = 1'b0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  tag, act, act, exp, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [AW-1:0] a0,
                                  input logic [DW-1:0] k1, k2, k3, g0, g1, g2);
      logic [AW:0]   s;
      logic [AW-1:0] a;
      logic [AW-1:0] p[3];
      exp_t          r;
      p[0] = 32'(k1) * 32'(g0);
      p[1] = 32'(k2) * 32'(g1);
      p[2] = 32'(k3) * 32'(g2);
      a     = a0;
      r.ovf = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s = {1'b0, a} + {1'b0, p[i]};
         if (s[AW]) r.ovf = 1'b1;
`ifdef REG_SAT_EN
         a = s[AW] ? {AW{1'b1}} : s[AW-1:0];
`else
         a = s[AW-1:0];
`endif
      end
      r.y = a;
      return r;
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: latency, hold-while-stalled, drop-after-handshake, scoreboard pop.
   logic          prev_ov = 1'b0;
   logic          hs_prev = 1'b0;
   logic [AW-1:0] held_y, last_y;
   logic          held_ovf;
   int            prev_acc;
   logic          have_prev = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      int   a;
      if (rst) begin
         acc_q.delete();
         prev_ov   = 1'b0;
         hs_prev   = 1'b0;
         have_prev = 1'b0;
      end else begin
         if (hs_prev) begin
            chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
            chk("y_keep", 64'(bus.y), 64'(last_y));
         end
         hs_prev = 1'b0;
         if (!tp_mode) have_prev = 1'b0;
         if (bus.in_valid && bus.in_ready) begin
            acc_q.push_back(cyc);
            if (tp_mode && have_prev) chk("throughput", 64'(cyc - prev_acc), 64'd5);
            prev_acc  = cyc;
            have_prev = 1'b1;
         end
         if (bus.out_valid) begin
            if (!prev_ov) begin
               held_y   = bus.y;
               held_ovf = bus.ovf;
               if (acc_q.size() > 0) begin
                  a = acc_q.pop_front();
                  chk("latency", 64'(cyc - a), 64'd4);
               end else begin
                  chk("latency_no_accept", 64'd1, 64'd0);
               end
            end else begin
               chk("hold_y", 64'(bus.y), 64'(held_y));
               chk("hold_ovf", 64'(bus.ovf), 64'(held_ovf));
            end
            chk("in_ready_in_done", 64'(bus.in_ready), 64'd0);
            if (bus.out_ready) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("y", 64'(bus.y), 64'(e.y));
                  chk("ovf", 64'(bus.ovf), 64'(e.ovf));
               end else begin
                  chk("unexpected_result", 64'd1, 64'd0);
               end
               hs_prev = 1'b1;
               last_y  = bus.y;
            end
         end
         prev_ov = bus.out_valid && !bus.out_ready;
      end
   end

   task automatic set_ops(input logic [AW-1:0] a0, input logic [DW-1:0] k1, k2, k3, g0, g1, g2);
      bus.c0 = a0; bus.c1 = k1; bus.c2 = k2; bus.c3 = k3;
      bus.f0 = g0; bus.f1 = g1; bus.f2 = g2;
   endtask

   // Drive one set and wait for its accept; returns 1 time unit after the accept edge.
   task automatic send(input logic [AW-1:0] a0, input logic [DW-1:0] k1, k2, k3, g0, g1, g2,
                       input logic [AW-1:0] ey, input logic eovf);
      exp_t e;
      int   n;
      e.y = ey; e.ovf = eovf;
      exp_q.push_back(e);
      set_ops(a0, k1, k2, k3, g0, g1, g2);
      bus.in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("accept_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("busy_after_accept", 64'(bus.busy), 64'd1);
   endtask

   task automatic send_model(input logic [AW-1:0] a0, input logic [DW-1:0] k1, k2, k3, g0, g1, g2);
      exp_t e;
      e = model(a0, k1, k2, k3, g0, g1, g2);
      send(a0, k1, k2, k3, g0, g1, g2, e.y, e.ovf);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("drain_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   n;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      set_ops('0, '0, '0, '0, '0, '0, '0);

      // Asynchronous reset, checked before the first clock edge.
      #1 rst = 1'b1;
      #2;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_y", 64'(bus.y), 64'd0);
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Nominal set.
      send(32'd50000, 16'd200, 16'd700, 16'd65, 16'd1000, 16'd30000, 16'd600, 32'd21289000, 1'b0);
      wait_drain();

      // All zeros.
      send('0, '0, '0, '0, '0, '0, '0, 32'd0, 1'b0);
      wait_drain();

      // Carry-out on the first term.
`ifdef REG_SAT_EN
      send(32'hFFFF_FFFF, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 32'hFFFF_FFFF, 1'b1);
`else
      send(32'hFFFF_FFFF, 16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 32'd0, 1'b1);
`endif
      wait_drain();

      // Consumer stalls 10 cycles; a second set offered meanwhile waits for IDLE.
      bus.out_ready = 1'b0;
      send(32'd50000, 16'd200, 16'd700, 16'd65, 16'd1000, 16'd30000, 16'd600, 32'd21289000, 1'b0);
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("out_valid_timeout", 64'd1, 64'd0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            send_exp_only: begin
               e = model(32'd7, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
               exp_q.push_back(e);
               set_ops(32'd7, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
               bus.in_valid = 1'b1;
            end
         end
         @(negedge clk);
         chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
         chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("second_accept_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      wait_drain();

      // Reset while the second term is being accumulated.
      send(32'd50000, 16'd200, 16'd700, 16'd65, 16'd1000, 16'd30000, 16'd600, 32'd21289000, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midrst_y", 64'(bus.y), 64'd0);
      chk("midrst_ovf", 64'(bus.ovf), 64'd0);
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      send(32'd50000, 16'd200, 16'd700, 16'd65, 16'd1000, 16'd30000, 16'd600, 32'd21289000, 1'b0);
      wait_drain();

      // Inputs scrambled during MAC must not affect the result.
      send(32'd50000, 16'd200, 16'd700, 16'd65, 16'd1000, 16'd30000, 16'd600, 32'd21289000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         set_ops($urandom, 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom));
         @(posedge clk); #1;
      end
      wait_drain();

      // Back-to-back random sets with out_ready high: one accept every 5 cycles.
      tp_mode = 1'b1;
      for (int i = 0; i < 12; i++) begin
         send_model($urandom, 16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom));
      end
      wait_drain();
      tp_mode = 1'b0;
      @(posedge clk); #1;

      // Random sets with small values (mostly no overflow).
      for (int i = 0; i < 8; i++) begin
         send_model(32'($urandom_range(0, 100000)), 16'($urandom_range(0, 300)),
                    16'($urandom_range(0, 300)), 16'($urandom_range(0, 300)),
                    16'($urandom_range(0, 300)), 16'($urandom_range(0, 300)),
                    16'($urandom_range(0, 300)));
         wait_drain();
      end

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
